// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: table size default and
// 2-bit saturating counter encodings.
package branch_predictor_pkg;

    localparam int ENTRY_BITS_DEF = 4;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

endpackage

// File: rtl/branch_predictor_btb_mem.sv
// Branch target buffer storage: valid/tag/target/counter arrays with two
// asynchronous read ports (IF lookup, EX update) and one synchronous write port.
module btb_mem
    import branch_predictor_pkg::*;
#(
    parameter int ENTRY_BITS = ENTRY_BITS_DEF,
    parameter int TAG_W      = 30 - ENTRY_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ENTRY_BITS-1:0] ra_idx,
    output logic                  ra_valid,
    output logic [TAG_W-1:0]      ra_tag,
    output logic [31:0]           ra_target,
    output logic [1:0]            ra_ctr,
    input  logic [ENTRY_BITS-1:0] rb_idx,
    output logic                  rb_valid,
    output logic [TAG_W-1:0]      rb_tag,
    output logic [31:0]           rb_target,
    output logic [1:0]            rb_ctr,
    input  logic                  we,
    input  logic [ENTRY_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_target,
    input  logic [1:0]            wr_ctr
);

    localparam int N = 1 << ENTRY_BITS;

    logic              valid_q  [N];
    logic [1:0]        ctr_q    [N];
    logic [TAG_W-1:0]  tag_q    [N];
    logic [31:0]       target_q [N];

    assign ra_valid  = valid_q[ra_idx];
    assign ra_tag    = tag_q[ra_idx];
    assign ra_target = target_q[ra_idx];
    assign ra_ctr    = ctr_q[ra_idx];

    assign rb_valid  = valid_q[rb_idx];
    assign rb_tag    = tag_q[rb_idx];
    assign rb_target = target_q[rb_idx];
    assign rb_ctr    = ctr_q[rb_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

    // Tag/target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: zero-latency IF lookup, EX-stage
// update, mispredict/redirect generation and resolved-branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRY_BITS = ENTRY_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic [31:0] pc_ex,
    input  logic        is_br_ex,
    input  logic        br_ex,
    input  logic [31:0] br_target_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    input  logic        stall_ex,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_W = 30 - ENTRY_BITS;

    function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == STRONG_T) ? STRONG_T : c + 2'd1;
        else
            return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
    endfunction

    logic              if_valid, ex_valid;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic [31:0]       if_target, ex_target;
    logic [1:0]        if_ctr, ex_ctr;
    logic              if_hit, ex_hit;
    logic              upd, we;
    logic [1:0]        wr_ctr;
    logic [31:0]       wr_target;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    btb_mem #(
        .ENTRY_BITS (ENTRY_BITS),
        .TAG_W      (TAG_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_idx    (pc_if[ENTRY_BITS+1:2]),
        .ra_valid  (if_valid),
        .ra_tag    (if_tag),
        .ra_target (if_target),
        .ra_ctr    (if_ctr),
        .rb_idx    (pc_ex[ENTRY_BITS+1:2]),
        .rb_valid  (ex_valid),
        .rb_tag    (ex_tag),
        .rb_target (ex_target),
        .rb_ctr    (ex_ctr),
        .we        (we),
        .wr_idx    (pc_ex[ENTRY_BITS+1:2]),
        .wr_tag    (pc_ex[31:ENTRY_BITS+2]),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

    assign if_hit      = if_valid & (if_tag == pc_if[31:ENTRY_BITS+2]);
    assign pred_taken  = if_hit & if_ctr[1];
    assign pred_target = pred_taken ? if_target : 32'h0;

    // A not-taken miss leaves the table alone; a taken miss allocates weakly taken.
    assign ex_hit    = ex_valid & (ex_tag == pc_ex[31:ENTRY_BITS+2]);
    assign upd       = is_br_ex & ~stall_ex;
    assign we        = upd & (ex_hit | br_ex);
    assign wr_ctr    = ex_hit ? ctr_update(ex_ctr, br_ex) : WEAK_T;
    assign wr_target = (ex_hit & ~br_ex) ? ex_target : br_target_ex;

    assign mispredict  = upd & ((br_ex != pred_taken_ex) |
                                (br_ex & (br_target_ex != pred_target_ex)));
    assign redirect_pc = br_ex ? br_target_ex : pc_ex + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt   <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (upd && br_cnt != 32'hFFFF_FFFF)
                br_cnt <= br_cnt + 32'd1;
            if (mispredict && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_branch_predictor;

    localparam int EB = 4;
    localparam int N  = 1 << EB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pc_ex;
    logic        is_br_ex;
    logic        br_ex;
    logic [31:0] br_target_ex;
    logic        pred_taken_ex;
    logic [31:0] pred_target_ex;
    logic        stall_ex;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRY_BITS(EB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_if          (pc_if),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pc_ex          (pc_ex),
        .is_br_ex       (is_br_ex),
        .br_ex          (br_ex),
        .br_target_ex   (br_target_ex),
        .pred_taken_ex  (pred_taken_ex),
        .pred_target_ex (pred_target_ex),
        .stall_ex       (stall_ex),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    int vectors = 0;
    int misses  = 0;

    // Behavioural model: table as plain arrays, counter as an integer 0..3
    bit          m_valid [N];
    int          m_ctr   [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    longint      m_br    = 0;
    longint      m_miss  = 0;
    bit          model_ok = 0;
    bit          done     = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == (pc >> (EB + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    function automatic bit m_misp();
        if (!is_br_ex || stall_ex) return 1'b0;
        return (br_ex != pred_taken_ex) || (br_ex && (br_target_ex != pred_target_ex));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    always begin
        @(negedge clk);
        if (model_ok && !done) begin
            chk("model pred_taken", {31'h0, pred_taken}, {31'h0, m_pred(pc_if)});
            chk("model pred_target", pred_target, m_ptgt(pc_if));
            chk("model mispredict", {31'h0, mispredict}, {31'h0, m_misp()});
            chk("model redirect_pc", redirect_pc, br_ex ? br_target_ex : pc_ex + 32'd4);
            chk("model br_cnt", br_cnt, (m_br > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_br[31:0]);
            chk("model miss_cnt", miss_cnt, (m_miss > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_miss[31:0]);
        end
        @(posedge clk);
        if (rst_n === 1'b0) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_br     = 0;
            m_miss   = 0;
            model_ok = 1;
        end else if (model_ok && is_br_ex && !stall_ex) begin
            int i;
            i = idx_of(pc_ex);
            if (m_misp()) m_miss++;
            m_br++;
            if (m_hit(pc_ex)) begin
                m_ctr[i] = br_ex ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                 : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (br_ex) m_tgt[i] = br_target_ex;
            end else if (br_ex) begin
                m_valid[i] = 1;
                m_tag[i]   = pc_ex >> (EB + 2);
                m_tgt[i]   = br_target_ex;
                m_ctr[i]   = 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptg);
        is_br_ex       = 1'b1;
        pc_ex          = pc;
        br_ex          = tk;
        br_target_ex   = tgt;
        pred_taken_ex  = pt;
        pred_target_ex = ptg;
    endtask

    function automatic logic [31:0] pool_pc();
        return (32'($urandom_range(0, 3)) << (EB + 2)) | (32'($urandom_range(0, N - 1)) << 2);
    endfunction

    initial begin
        rst_n = 1'b0; pc_if = 32'h0; stall_ex = 1'b0;
        br(32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
        tick(); tick();

        rst_n = 1'b1; is_br_ex = 1'b0; pc_if = 32'h100; #2;
        chk("reset pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("reset pred_target", pred_target, 32'h0);
        chk("reset br_cnt", br_cnt, 32'h0);

        br(32'h100, 1'b1, 32'h140, 1'b0, 32'h0); #2;
        chk("first taken mispredict", {31'h0, mispredict}, 32'h1);
        chk("first taken redirect", redirect_pc, 32'h140);
        tick(); is_br_ex = 1'b0; #2;
        chk("alloc miss_cnt", miss_cnt, 32'h1);
        chk("alloc pred_taken", {31'h0, pred_taken}, 32'h1);
        chk("alloc pred_target", pred_target, 32'h140);

        for (int k = 0; k < 2; k++) begin
            br(32'h100, 1'b1, 32'h140, 1'b1, 32'h140); #2;
            chk("taken hit mispredict", {31'h0, mispredict}, 32'h0);
            tick();
        end
        br(32'h100, 1'b0, 32'h999, 1'b1, 32'h140); #2;
        chk("nt1 mispredict", {31'h0, mispredict}, 32'h1);
        chk("nt1 redirect", redirect_pc, 32'h104);
        tick(); is_br_ex = 1'b0; #2;
        chk("ctr 10 pred_taken", {31'h0, pred_taken}, 32'h1);
        br(32'h100, 1'b0, 32'h999, 1'b0, 32'h0); #2;
        chk("nt2 mispredict", {31'h0, mispredict}, 32'h0);
        tick(); is_br_ex = 1'b0; #2;
        chk("ctr 01 pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("ctr 01 pred_target", pred_target, 32'h0);
        chk("seq br_cnt", br_cnt, 32'd5);
        chk("seq miss_cnt", miss_cnt, 32'd2);

        br(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
        tick(); is_br_ex = 1'b0; pc_if = 32'h100; #2;
        chk("alias old pc", {31'h0, pred_taken}, 32'h0);
        pc_if = 32'h140; #2;
        chk("alias new pc", {31'h0, pred_taken}, 32'h1);
        chk("alias new target", pred_target, 32'h200);

        br(32'h300, 1'b1, 32'h400, 1'b0, 32'h0); stall_ex = 1'b1; #2;
        chk("stall mispredict", {31'h0, mispredict}, 32'h0);
        tick(); stall_ex = 1'b0; is_br_ex = 1'b0; pc_if = 32'h300; #2;
        chk("stall no alloc", {31'h0, pred_taken}, 32'h0);
        chk("stall br_cnt", br_cnt, 32'd6);
        chk("stall miss_cnt", miss_cnt, 32'd3);

        br(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1, 32'h500); #2;
        chk("wrap mispredict", {31'h0, mispredict}, 32'h1);
        chk("wrap redirect", redirect_pc, 32'h0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = pool_pc();
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) != 0)
                br(pc, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4,
                   m_pred(pc), m_ptgt(pc));
            else
                br(pc, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4,
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4);
            is_br_ex = ($urandom_range(0, 3) != 0);
            stall_ex = ($urandom_range(0, 7) == 0);
            pc_if    = ($urandom_range(0, 1) != 0) ? pc : pool_pc();
            tick();
        end

        rst_n = 1'b0; stall_ex = 1'b0;
        br(32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1; is_br_ex = 1'b0;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                pc_if = (32'(t) << (EB + 2)) | (32'(i) << 2); #1;
                chk("post-reset invalid", {31'h0, pred_taken}, 32'h0);
            end
        end
        chk("post-reset br_cnt", br_cnt, 32'h0);
        chk("post-reset miss_cnt", miss_cnt, 32'h0);
        done = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
